// File: rtl/xnor_sweep_checker.sv
`timescale 1ns / 1ps
// xnor_sweep_checker
//
// Clocked sweep engine for a 2-input gate under test (default truth table: XNOR).
// It drives {a,b} through 00, 01, 10 and 11. Each vector is held for SETTLE_CYCLES
// cycles, and y is then sampled on the closing edge of one further SAMPLE cycle.
// The engine compares each sample against EXPECT[{a,b}]. It accumulates a mismatch
// count and a per-vector fail map, and reports pass/fail once the sweep completes.
//
// Parameters
//   SETTLE_CYCLES  cycles between driving a vector and its sample cycle (1..255)
//   EXPECT         expected y per vector, bit i for {a,b} == i (4'b1001 = XNOR)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   sweep request, only honoured in IDLE
//   a, b      out  registered stimulus to the gate under test
//   y         in   gate response, sampled without a synchroniser
//   busy      out  high while a vector is settling or being sampled
//   done      out  one-cycle pulse when a sweep finishes
//   pass      out  last completed sweep had no mismatches
//   err_cnt   out  mismatching vectors in the current/last sweep (0..4)
//   fail_vec  out  bit i set when vector i mismatched
//   vec_idx   out  index of the vector currently driven
//
// Optional feature
//   XNOR_SWEEP_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep.
module xnor_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT        = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [1:0] vec_idx
);

  localparam logic [7:0] SettleLoad = SETTLE_CYCLES[7:0];
  localparam logic [3:0] ExpTab     = EXPECT;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] ab_q, ab_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  assign mismatch = (y != ExpTab[vec_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    ab_d    = ab_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d   = 2'd0;
          ab_d    = 2'd0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end

      StSettle: begin
        // The loaded value counts down to 1, so SETTLE lasts SETTLE_CYCLES cycles.
        if (cnt_q <= 8'd1) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StSample: begin
        if (mismatch) begin
          // At most four vectors are checked, so the 3-bit count cannot wrap.
          err_d         = err_q + 3'd1;
          fail_d[vec_q] = 1'b1;
        end
`ifdef XNOR_SWEEP_STOP_ON_FAIL_EN
        if (mismatch) begin
          ab_d    = 2'd0;
          pass_d  = 1'b0;
          state_d = StDone;
        end else
`endif
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else begin
          ab_d    = 2'd0;
          pass_d  = (err_d == 3'd0);
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      vec_q   <= 2'd0;
      ab_q    <= 2'd0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign a        = ab_q[1];
  assign b        = ab_q[0];
  assign busy     = (state_q == StSettle) || (state_q == StSample);
  assign done     = (state_q == StDone);
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;
  assign vec_idx  = vec_q;

endmodule

// File: tb/tb_xnor_sweep_checker.sv
`timescale 1ns / 1ps
// Bench for xnor_sweep_checker: a behavioural gate with a programmable truth table
// drives y, and a small reference model predicts the trace and results of each sweep.
module tb_xnor_sweep_checker;

  localparam int unsigned S   = 2;
  localparam logic [3:0]  EXP = 4'b1001;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic [1:0] vec_idx;

  logic [3:0] gate_tab;
  int         n_checks;
  int         n_fails;

  assign y = gate_tab[{a, b}];

  xnor_sweep_checker #(
    .SETTLE_CYCLES(S),
    .EXPECT       (EXP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .fail_vec(fail_vec),
    .vec_idx (vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep against gate truth table tab and checks every cycle up to and after DONE.
  // Called from the #1-after-edge sampling point with the checker in IDLE.
  task automatic run_sweep(input logic [3:0] tab);
    int         n_applied;
    int         e_err;
    logic [3:0] e_fail;
    int         done_k;
    n_applied = 0;
    e_err     = 0;
    e_fail    = 4'd0;
    for (int v = 0; v < 4; v++) begin
      n_applied++;
      if (tab[v] != EXP[v]) begin
        e_fail[v] = 1'b1;
        e_err++;
`ifdef XNOR_SWEEP_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    done_k = n_applied * (S + 1);

    gate_tab = tab;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("cleared_pass", pass, 0);
    check("cleared_err", err_cnt, 0);
    check("cleared_fail", fail_vec, 0);
    for (int k = 0; k < done_k; k++) begin
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("ab", {a, b}, k / (S + 1));
      check("vec_idx", vec_idx, k / (S + 1));
      tick();
    end
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("ab_in_done", {a, b}, 0);
    check("pass", pass, (e_err == 0));
    check("err_cnt", err_cnt, e_err);
    check("fail_vec", fail_vec, e_fail);
    tick();
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("held_err", err_cnt, e_err);
    check("held_fail", fail_vec, e_fail);
    check("held_pass", pass, (e_err == 0));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    gate_tab = 4'b1001;
    start    = 1'b0;
    rst_n    = 1'b0;
    #3;
    check("rst_ab", {a, b}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fail", fail_vec, 0);
    check("rst_vec", vec_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed gates: correct XNOR, stuck-at-0, XOR.
    run_sweep(4'b1001);
    run_sweep(4'b0000);
    run_sweep(4'b0110);

    // Random truth tables.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] t;
      t = 4'($urandom_range(0, 15));
      run_sweep(t);
    end

    // start held high: one sweep per busy window, DONE ignores start,
    // second accept on the first edge seen in IDLE (after E13 -> accept at E14).
    gate_tab = 4'b1001;
    start    = 1'b1;
    for (int k = 0; k < 28; k++) begin
      tick();
      if (k == 19) start = 1'b0;
      check("hold_busy", busy, (k < 12) || (k >= 14 && k < 26));
      check("hold_done", done, (k == 12) || (k == 26));
      if (k == 12 || k == 13) check("hold_pass_set", pass, 1);
      if (k == 14) check("hold_pass_clr", pass, 0);
    end
    tick();

    // Asynchronous reset mid-sweep with a failing gate.
    gate_tab = 4'b0110;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ab", {a, b}, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_pass", pass, 0);
    check("arst_err", err_cnt, 0);
    check("arst_fail", fail_vec, 0);
    check("arst_vec", vec_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(4'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
